// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 8x16 register file: round-robin arbitration between
// ALU (A) and load (B) writebacks, a registered write stage, and a busy scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int NUM_REG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_stall,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  output logic [NUM_REG-1:0] busy_vec
);

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  ptr_e               ptr_q, ptr_d;
  logic               grant_a, grant_b;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REG-1:0] busy_q, busy_d;

  // Arbitration: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    ptr_d   = ptr_q;
    if (!rst) begin
      if (a_valid && (!b_valid || ptr_q == PTR_A)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
    if (grant_a) begin
      ptr_d = PTR_B;
    end else if (grant_b) begin
      ptr_d = PTR_A;
    end
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign issue_stall = issue_en & busy_q[issue_dest];

  always_comb begin
    we_d   = grant_a | grant_b;
    dest_d = dest_q;
    data_d = data_q;
    if (grant_a) begin
      dest_d = a_dest;
      data_d = a_data;
    end else if (grant_b) begin
      dest_d = b_dest;
      data_d = b_data;
    end
  end

  // Clear for the landing write is applied first so a same-edge reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[dest_q] = 1'b0;
    end
    if (issue_en && !busy_q[issue_dest]) begin
      busy_d[issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= PTR_A;
      we_q   <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      dest_q <= dest_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign reg_write_en   = we_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;
  assign busy_vec       = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write scoreboard and busy model.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        issue_en;
  logic [2:0]  issue_dest;
  logic        issue_stall;
  logic        a_valid, a_ready;
  logic [2:0]  a_dest;
  logic [15:0] a_data;
  logic        b_valid, b_ready;
  logic [2:0]  b_dest;
  logic [15:0] b_data;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [7:0]  busy_vec;

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3), .NUM_REG(8)) dut (
    .clk(clk), .rst(rst),
    .issue_en(issue_en), .issue_dest(issue_dest), .issue_stall(issue_stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  d;
    logic [15:0] v;
  } wr_t;

  wr_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  logic        we_m = 1'b0;
  logic [2:0]  dest_m = '0;
  logic [15:0] data_m = '0;
  logic [7:0]  busy_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ie, input logic [2:0] id,
                       input logic av, input logic [2:0] ad, input logic [15:0] adat,
                       input logic bv, input logic [2:0] bd, input logic [15:0] bdat);
    rst = r; issue_en = ie; issue_dest = id;
    a_valid = av; a_dest = ad; a_data = adat;
    b_valid = bv; b_dest = bd; b_data = bdat;
  endtask

  // One clock: check handshake outputs, queue expected writes, then check the edge result.
  task automatic cyc(input logic ea, input logic eb, input logic es);
    wr_t        w;
    logic [7:0] nb;
    logic       rst_s;
    #1;
    check("a_ready", 32'(a_ready), 32'(ea));
    check("b_ready", 32'(b_ready), 32'(eb));
    check("issue_stall", 32'(issue_stall), 32'(es));
    if (ea) sb.push_back('{a_dest, a_data});
    if (eb) sb.push_back('{b_dest, b_data});
    rst_s = rst;
    if (rst) begin
      nb = '0;
    end else begin
      nb = busy_m;
      if (we_m) nb[dest_m] = 1'b0;
      if (issue_en && !es) nb[issue_dest] = 1'b1;
    end
    @(posedge clk);
    #1;
    busy_m = nb;
    if (rst_s) begin
      sb.delete();
      we_m = 1'b0; dest_m = '0; data_m = '0;
      check("rst_write_en", 32'(reg_write_en), 32'(1'b0));
    end else begin
      we_m = (sb.size() != 0);
      check("reg_write_en", 32'(reg_write_en), 32'(we_m));
      if (reg_write_en === 1'b1 && sb.size() != 0) begin
        w = sb.pop_front();
        dest_m = w.d;
        data_m = w.v;
      end
    end
    check("reg_write_dest", 32'(reg_write_dest), 32'(dest_m));
    check("reg_write_data", 32'(reg_write_data), 32'(data_m));
    check("busy_vec", 32'(busy_vec), 32'(busy_m));
  endtask

  initial begin
    drive(1, 0, 0, 1, 3'd1, 16'h1234, 1, 3'd2, 16'h5678);
    // Reset: readies held low even with both requests up
    cyc(0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);

    // Reserve r3, then A writes it; busy[3] drops once the write lands
    drive(0, 1, 3'd3, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    drive(0, 0, 0, 1, 3'd3, 16'hABCD, 0, 0, 0);
    cyc(1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);

    // Contention from reset: A, B, A, then B alone
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    drive(0, 0, 0, 1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    drive(0, 0, 0, 1, 3'd1, 16'h3333, 1, 3'd2, 16'h4444);
    cyc(1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 3'd2, 16'h4444);
    cyc(0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);

    // Stall on busy r5; then same-edge commit and reservation of r5
    drive(0, 1, 3'd5, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    drive(0, 1, 3'd5, 1, 3'd5, 16'h5555, 0, 0, 0);
    cyc(1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    drive(0, 0, 0, 1, 3'd5, 16'h6666, 0, 0, 0);
    cyc(1, 0, 0);
    drive(0, 1, 3'd5, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);

    // B alone, three consecutive writes
    drive(0, 0, 0, 0, 0, 0, 1, 3'd4, 16'h0404);
    cyc(0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 3'd5, 16'h0505);
    cyc(0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 3'd6, 16'h0606);
    cyc(0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);

    // Reset right after an A grant: busy cleared, pointer back to A
    drive(0, 1, 3'd2, 1, 3'd7, 16'h7777, 0, 0, 0);
    cyc(1, 0, 0);
    drive(1, 0, 0, 1, 3'd1, 16'h8888, 1, 3'd0, 16'h9999);
    cyc(0, 0, 0);
    drive(0, 0, 0, 1, 3'd1, 16'h8888, 1, 3'd0, 16'h9999);
    cyc(1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
